uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver with an integrated oversampling baud-tick generator.
//  Configurable data width, parity mode and stop-bit count.
//  Flags parity and framing errors, and rejects start-bit glitches.
//  Sits between the board RX pin and the byte-consuming logic.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  9600        line rate, bit/s
//  OVERSAMPLE 16          ticks per bit; even, >=8
//  DATA_BITS  8           payload bits per frame, 5..9, LSB first
//  PARITY     0           0 = none, 1 = even, 2 = odd
//  STOP_BITS  1           1 or 2
// PORTS
//  i_clk        in   1          system clock, rising edge
//  i_reset      in   1          asynchronous, active-low reset
//  i_rx         in   1          serial line; idle high; asynchronous to i_clk
//  o_rx_done    out  1          one-cycle pulse: frame complete, outputs valid
//  o_data       out  DATA_BITS  last received payload; held until next o_rx_done
//  o_parity_err out  1          parity mismatch on last frame; 0 if PARITY=0
//  o_frame_err  out  1          a stop bit was sampled low on last frame
// BEHAVIOUR
//  Reset (i_reset=0):
//  - All outputs 0, FSM=IDLE, counters 0.
//  - Synchroniser flops preset to 1.
//  - Reset mid-frame aborts the frame; no o_rx_done is produced.
//  Synchroniser:
//  - i_rx passes through 2 flops; rx_s is the synchronised value.
//  - Adds 2 cycles of latency; all FSM decisions use rx_s.
//  Tick generator:
//  - DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE); default 326.
//  - Counter runs 0..DIV-1 freely and asserts tick for 1 cycle at DIV-1.
//  - Sample counter s_cnt ($clog2(OVERSAMPLE) bits) advances on tick only.
//  FSM (transitions only on tick cycles):
//  - IDLE: rx_s==0 on a tick -> START, s_cnt=0.
//  - START: at s_cnt==OVERSAMPLE/2-1 (mid start bit):
//    - rx_s==1 -> IDLE (glitch rejected, no output change).
//    - rx_s==0 -> DATA, s_cnt=0, bit index=0.
//  - DATA: every OVERSAMPLE ticks, shift rx_s in at MSB; after DATA_BITS samples, go to
//    PARITY if PARITY!=0, else STOP.
//  - PARITY: one sample; p_err = (^data ^ rx_s) != (PARITY==2).
//  - STOP: one sample per stop bit; f_err accumulates any 0 sample.
//  - At mid last stop bit, same cycle: o_rx_done=1 for 1 clk; o_data, o_parity_err and
//    o_frame_err load.
//  - Next state: f_err ? WAIT_IDLE : IDLE.
//  - WAIT_IDLE: stay until rx_s==1 on a tick, then IDLE. Prevents a stuck-low line
//    (break) from retriggering frames.
//  Back-to-back frames:
//  - Returning to IDLE at mid stop bit leaves 1/2 bit of margin, so a start bit
//    immediately following is detected.
//  Timing:
//  - o_rx_done occurs (1 + DATA_BITS + (PARITY!=0) + STOP_BITS - 0.5) bit times after
//    the falling edge, quantised to +1/OVERSAMPLE bit.
//  - Plus 2-3 clk of synchroniser latency.
//  - Error flags are sticky only until the next o_rx_done.
// TESTING
//  - Default params; send 0x55 8N1 at 104167 ns/bit:
//    -> exactly one o_rx_done ~989.6 us after start edge (+-7 us);
//       o_data=0x55, both error flags 0.
//  - rx low for 2 us, then high:
//    -> no o_rx_done within 2 ms; FSM back in IDLE.
//  - PARITY=1; send 0xA5 with parity bit 1 (wrong):
//    -> o_data=0xA5, o_parity_err=1. Resend with parity 0 -> o_parity_err=0.
//  - Send 0x3C with stop bit 0, then line held low 3 bit times, then 0x3C correct:
//    -> first frame o_frame_err=1; no frame during low hold;
//       second frame o_data=0x3C, o_frame_err=0.
//  - Send 0x00 then 0xFF with zero idle gap; separately with STOP_BITS=2, DATA_BITS=7:
//    -> two pulses, data 0x00 then 0xFF (0x7F when DATA_BITS=7).
//  - Assert i_reset=0 during bit 4 of a frame, release, send 0x81:
//    -> outputs 0 during reset, no pulse for the aborted frame, next o_data=0x81.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   UART receiver with a built-in oversampling baud-tick generator. Sits between
//   the board RX pin and byte-consuming logic. Payload width, parity mode and
//   stop-bit count are parameters. Start-bit glitches shorter than half a bit are
//   rejected. A frame whose stop bit reads low parks the receiver until the line
//   returns high, so a held-low line (break) cannot retrigger frames.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_rx          serial line, idle high, asynchronous to i_clk
//   o_rx_done     one-cycle pulse: frame complete, o_data and flags valid
//   o_data        last received payload (LSB first on the wire), held until next pulse
//   o_parity_err  parity mismatch on last frame (always 0 when PARITY = 0)
//   o_frame_err   a stop bit of the last frame was sampled low
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,  // ticks per bit, even, >= 8
  parameter int DATA_BITS  = 8,   // 5..9
  parameter int PARITY     = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic                 o_rx_done,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err
);

  // Rounded clock divider for one oversample tick.
  localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MID     = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_END     = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST    = B_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, preset to the idle (high) line level so that reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [1:0] rx_sync;
  logic       rx_s;

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], i_rx};
  end

  assign rx_s = rx_sync[1];

  // ---------------------------------------------------------------------------
  // Free-running oversample tick generator.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Receive FSM. All decisions are taken on tick cycles using rx_s.
  // ---------------------------------------------------------------------------
  state_t               state, state_d;
  logic [S_W-1:0]       s_cnt, s_cnt_d;
  logic [B_W-1:0]       bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 p_err, p_err_d;
  logic                 f_err, f_err_d;
  logic                 rx_done_d;
  logic                 s_end;

  assign s_end = (s_cnt == S_END);

  always_comb begin
    // NOTE: every variable assigned below gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d    = state;
    s_cnt_d    = s_cnt;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    shreg_d    = shreg;
    p_err_d    = p_err;
    f_err_d    = f_err;
    rx_done_d  = 1'b0;

    if (tick) begin
      s_cnt_d = s_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          s_cnt_d = '0;
          if (!rx_s) state_d = S_START;
        end

        // Mid start bit: a line already back high was only a glitch.
        S_START: begin
          if (s_cnt == S_MID) begin
            s_cnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              bit_idx_d  = '0;
              stop_idx_d = 1'b0;
              p_err_d    = 1'b0;
              f_err_d    = 1'b0;
            end
          end
        end

        // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
        S_DATA: begin
          if (s_end) begin
            s_cnt_d   = '0;
            shreg_d   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx_d = bit_idx + 1'b1;
            if (bit_idx == B_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          if (s_end) begin
            s_cnt_d = '0;
            p_err_d = ((^shreg) ^ rx_s) != ODD_PAR;
            state_d = S_STOP;
          end
        end

        // The frame completes at the middle of the last stop bit, leaving half
        // a bit of margin to catch a start bit that follows with no gap.
        S_STOP: begin
          if (s_end) begin
            s_cnt_d    = '0;
            f_err_d    = f_err | ~rx_s;
            stop_idx_d = stop_idx + 1'b1;
            if (stop_idx == STOP_LAST) begin
              rx_done_d = 1'b1;
              state_d   = f_err_d ? S_WAIT_IDLE : S_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          s_cnt_d = '0;
          if (rx_s) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the shift register and error accumulators are reset along with the
  // control state, so nothing downstream can observe an X after reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      s_cnt    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
    end else begin
      state    <= state_d;
      s_cnt    <= s_cnt_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      shreg    <= shreg_d;
      p_err    <= p_err_d;
      f_err    <= f_err_d;
    end
  end

  // Output registers: loaded together with the done pulse, held otherwise.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rx_done    <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_rx_done <= rx_done_d;
      if (rx_done_d) begin
        o_data       <= shreg;
        o_parity_err <= p_err;
        o_frame_err  <= f_err_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Four receivers with different frame formats share clock and reset, each on
//   its own serial line. Bit time is exactly 64 clocks on every instance
//   (DIV = 4 with 16x oversampling, DIV = 8 with 8x). The reference model works
//   at frame level: it knows what payload, parity and stop bits were put on the
//   wire and derives the expected payload, flags and completion latency.
//     u0: 8N1   u1: 8E1   u2: 7N2   u3: 5O1 (8x oversampling)
module tb_uart_rx_param;

  localparam int CLK_HALF = 5;
  localparam int CLK_P    = 2 * CLK_HALF;
  localparam int BIT_T    = 64 * CLK_P;
  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int LOG_N    = 64;
  localparam int WATCHDOG = 90_000 * CLK_P;

  logic tb_clk = 1'b0;
  always #(CLK_HALF) tb_clk = ~tb_clk;

  logic       rst_n;
  logic [3:0] rx_v;
  logic [3:0] done_v, pe_v, fe_v;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [4:0] d3;
  logic [8:0] data_v [4];

  assign data_v[0] = {1'b0, d0};
  assign data_v[1] = {1'b0, d1};
  assign data_v[2] = {2'b0, d2};
  assign data_v[3] = {4'b0, d3};

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(tb_clk), .i_reset(rst_n), .i_rx(rx_v[0]), .o_rx_done(done_v[0]),
    .o_data(d0), .o_parity_err(pe_v[0]), .o_frame_err(fe_v[0]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .i_clk(tb_clk), .i_reset(rst_n), .i_rx(rx_v[1]), .o_rx_done(done_v[1]),
    .o_data(d1), .o_parity_err(pe_v[1]), .o_frame_err(fe_v[1]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .i_clk(tb_clk), .i_reset(rst_n), .i_rx(rx_v[2]), .o_rx_done(done_v[2]),
    .o_data(d2), .o_parity_err(pe_v[2]), .o_frame_err(fe_v[2]));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(8),
                  .DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) u3 (
    .i_clk(tb_clk), .i_reset(rst_n), .i_rx(rx_v[3]), .o_rx_done(done_v[3]),
    .o_data(d3), .o_parity_err(pe_v[3]), .o_frame_err(fe_v[3]));

  // Frame format of each channel, mirroring the instance parameters above.
  function automatic int dbits_of(input int ch);
    case (ch)
      2:       return 7;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int par_of(input int ch);
    case (ch)
      1:       return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stops_of(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  function automatic int os_of(input int ch);
    return (ch == 3) ? 8 : 16;
  endfunction

  // Bookkeeping
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt [4] = '{default: 0};
  int         exp_cnt  [4] = '{default: 0};
  logic [8:0] log_data [4][LOG_N];
  logic       log_pe   [4][LOG_N];
  logic       log_fe   [4][LOG_N];
  time        log_t    [4][LOG_N];
  logic [8:0] mdl_data [4];
  logic       mdl_pe   [4];
  logic       mdl_fe   [4];
  time        t_start  [4];

  // Capture every completion pulse away from the active edge.
  always @(negedge tb_clk) begin
    for (int c = 0; c < 4; c++) begin
      if (done_v[c] === 1'b1) begin
        if (done_cnt[c] < LOG_N) begin
          log_data[c][done_cnt[c]] = data_v[c];
          log_pe[c][done_cnt[c]]   = pe_v[c];
          log_fe[c][done_cnt[c]]   = fe_v[c];
          log_t[c][done_cnt[c]]    = $time;
        end
        done_cnt[c] = done_cnt[c] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int ch, input logic v);
    rx_v[ch] = v;
    #(BIT_T);
  endtask

  // Put one frame on line ch and record what the receiver must report.
  // stop_pat[i] is the level driven for stop bit i.
  task automatic send_frame(input int ch, input logic [8:0] data, input bit bad_par,
                            input logic [1:0] stop_pat);
    logic [8:0] d;
    logic       pb;
    logic       any_low;
    d       = data & 9'((1 << dbits_of(ch)) - 1);
    any_low = 1'b0;
    t_start[ch] = $time;
    drive(ch, 1'b0);
    for (int i = 0; i < dbits_of(ch); i++) drive(ch, d[i]);
    if (par_of(ch) != 0) begin
      // Even parity: data plus parity bit carry an even number of ones.
      pb = ($countones(d) % 2) == 1;
      if (par_of(ch) == 2) pb = ~pb;
      if (bad_par) pb = ~pb;
      drive(ch, pb);
    end
    for (int i = 0; i < stops_of(ch); i++) begin
      drive(ch, stop_pat[i]);
      if (!stop_pat[i]) any_low = 1'b1;
    end
    mdl_data[ch] = d;
    mdl_pe[ch]   = (par_of(ch) != 0) && bad_par;
    mdl_fe[ch]   = any_low;
  endtask

  // Compare the next completion on ch against the model, including latency
  // measured from the start-bit edge.
  task automatic expect_next(input int ch, input string tag);
    int  k;
    int  waited;
    int  nbits;
    time lo, hi, dly;
    k      = exp_cnt[ch];
    waited = 0;
    while (done_cnt[ch] <= k && waited < 4 * 64) begin
      #(CLK_P);
      waited++;
    end
    check({tag, "_cnt"}, 32'(done_cnt[ch]), 32'(k + 1));
    if (k < LOG_N) begin
      check({tag, "_data"}, 32'(log_data[ch][k]), 32'(mdl_data[ch]));
      check({tag, "_perr"}, 32'(log_pe[ch][k]),   32'(mdl_pe[ch]));
      check({tag, "_ferr"}, 32'(log_fe[ch][k]),   32'(mdl_fe[ch]));
      nbits = 1 + dbits_of(ch) + ((par_of(ch) != 0) ? 1 : 0) + stops_of(ch);
      lo    = time'(nbits * BIT_T - BIT_T / 2);
      hi    = lo + time'(BIT_T / os_of(ch) + 5 * CLK_P);
      dly   = log_t[ch][k] - t_start[ch];
      check({tag, "_lat_ok"}, 32'(dly >= lo && dly <= hi), 32'd1);
    end
    exp_cnt[ch] = k + 1;
  endtask

  initial begin
    #(WATCHDOG);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] rd;
    bit         bp;
    logic [1:0] sp;

    rst_n = 1'b0;
    rx_v  = '1;
    #3;
    #(4 * CLK_P);

    // Reset state
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_perr", 32'(pe_v),   32'd0);
    check("rst_ferr", 32'(fe_v),   32'd0);
    check("rst_d0",   32'(d0),     32'd0);
    check("rst_d2",   32'(d2),     32'd0);
    check("rst_d3",   32'(d3),     32'd0);
    rst_n = 1'b1;
    #(2 * BIT_T);

    // Single 8N1 frame, with latency and single-pulse checks
    send_frame(0, 9'h055, 1'b0, 2'b11);
    expect_next(0, "a55");
    #(3 * BIT_T);
    check("a55_single", 32'(done_cnt[0]), 32'd1);

    // Start-bit glitch of 1/8 bit: rejected, receiver still usable
    rx_v[0] = 1'b0;
    #(BIT_T / 8);
    rx_v[0] = 1'b1;
    #(20 * BIT_T);
    check("glitch_nopulse", 32'(done_cnt[0]), 32'(exp_cnt[0]));
    send_frame(0, 9'h0C3, 1'b0, 2'b11);
    expect_next(0, "glitch_after");

    // Bad stop bit, line held low 3 bits (no frames), then a good frame
    send_frame(0, 9'h03C, 1'b0, 2'b00);
    expect_next(0, "ferr_bad");
    #(3 * BIT_T);
    check("ferr_hold_nopulse", 32'(done_cnt[0]), 32'(exp_cnt[0]));
    rx_v[0] = 1'b1;
    #(BIT_T);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    expect_next(0, "ferr_good");

    // Back-to-back frames with no idle gap
    send_frame(0, 9'h000, 1'b0, 2'b11);
    expect_next(0, "b2b_00");
    send_frame(0, 9'h0FF, 1'b0, 2'b11);
    expect_next(0, "b2b_ff");
    send_frame(2, 9'h000, 1'b0, 2'b11);
    expect_next(2, "b2b7_00");
    send_frame(2, 9'h07F, 1'b0, 2'b11);
    expect_next(2, "b2b7_7f");
    // Only the second of two stop bits low
    send_frame(2, 9'h02A, 1'b0, 2'b01);
    expect_next(2, "stop2_bad");
    rx_v[2] = 1'b1;
    #(BIT_T);

    // Even parity: wrong, right, wrong; odd parity: right, wrong
    send_frame(1, 9'h0A5, 1'b1, 2'b11);
    expect_next(1, "par_a5_bad");
    send_frame(1, 9'h0A5, 1'b0, 2'b11);
    expect_next(1, "par_a5_good");
    send_frame(1, 9'h0A5, 1'b1, 2'b11);
    expect_next(1, "par_a5_bad2");
    send_frame(3, 9'h015, 1'b0, 2'b11);
    expect_next(3, "odd_15_good");
    send_frame(3, 9'h00A, 1'b1, 2'b11);
    expect_next(3, "odd_0a_bad");

    // Reset during data bit 4 of a frame on u0
    drive(0, 1'b0);
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b1);
    rx_v[0] = 1'b1;
    #(BIT_T / 2);
    rst_n = 1'b0;
    #(CLK_P);
    check("abort_rst_done", 32'(done_v), 32'd0);
    check("abort_rst_perr", 32'(pe_v),   32'd0);
    check("abort_rst_ferr", 32'(fe_v),   32'd0);
    check("abort_rst_d0",   32'(d0),     32'd0);
    check("abort_rst_d1",   32'(d1),     32'd0);
    check("abort_rst_d2",   32'(d2),     32'd0);
    #(BIT_T / 2 - CLK_P);
    #(BIT_T);
    rst_n = 1'b1;
    #(12 * BIT_T);
    check("abort_nopulse", 32'(done_cnt[0]), 32'(exp_cnt[0]));
    send_frame(0, 9'h081, 1'b0, 2'b11);
    expect_next(0, "abort_81");

    // Randomised frames: payload, parity errors, stop errors, idle gaps
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int f = 0; f < 2; f++) begin
          rd = 9'($urandom);
          bp = (par_of(ch) != 0) && ($urandom_range(0, 3) == 0);
          sp = 2'b11;
          if ($urandom_range(0, 4) == 0) sp[0] = 1'b0;
          if (stops_of(ch) == 2 && $urandom_range(0, 4) == 0) sp[1] = 1'b0;
          send_frame(ch, rd, bp, sp);
          expect_next(ch, "rand");
          if (rx_v[ch] == 1'b0 || $urandom_range(0, 1) == 1) begin
            rx_v[ch] = 1'b1;
            #(BIT_T);
          end
        end
      end
    end

    #(2 * BIT_T);
    for (int ch = 0; ch < 4; ch++) begin
      check("final_count", 32'(done_cnt[ch]), 32'(exp_cnt[ch]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
